// File: rtl/icecream_vend_ctrl.sv
// Vend controller behind the recipe checker: takes an approved selection, collects
// coins, times the dispenser, then returns change or a refund.
module icecream_vend_ctrl #(
  parameter int unsigned PRICE           = 30,
  parameter int unsigned DISPENSE_CYCLES = 8,
  parameter int unsigned TIMEOUT         = 255,
  parameter int unsigned CREDIT_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                order_valid,
  input  logic                Sa,
  input  logic                Sw,
  input  logic                I,
  input  logic                P,
  input  logic                y,
  input  logic                coin_valid,
  input  logic [1:0]          coin_val,
  input  logic                cancel,
  output logic                order_ready,
  output logic                busy,
  output logic [3:0]          recipe,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic                reject,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt
);

  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned DCNT_W = $clog2(DISPENSE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PAY      = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          recipe_q, recipe_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic                dispense_q, dispense_d;
  logic                reject_q, reject_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_amt_q, change_amt_d;

  logic [CREDIT_W-1:0] coin_amt_c;
  logic [CREDIT_W:0]   coin_sum_c;
  logic [CREDIT_W-1:0] credit_add_c;
  logic [CREDIT_W-1:0] refund_c;
  logic [TMO_W-1:0]    tmo_inc_c;

  // Coin decode and saturating credit accumulation
  always_comb begin
    coin_amt_c = CREDIT_W'(5);
    case (coin_val)
      2'b00:   coin_amt_c = CREDIT_W'(5);
      2'b01:   coin_amt_c = CREDIT_W'(10);
      2'b10:   coin_amt_c = CREDIT_W'(20);
      default: coin_amt_c = CREDIT_W'(50);
    endcase
    coin_sum_c   = {1'b0, credit_q} + {1'b0, coin_amt_c};
    credit_add_c = coin_sum_c[CREDIT_W] ? '1 : coin_sum_c[CREDIT_W-1:0];
    refund_c     = coin_valid ? credit_add_c : credit_q;
    tmo_inc_c    = tmo_q + TMO_W'(1);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    recipe_d       = recipe_q;
    credit_d       = credit_q;
    tmo_d          = tmo_q;
    dcnt_d         = dcnt_q;
    dispense_d     = 1'b0;
    reject_d       = 1'b0;
    change_valid_d = 1'b0;
    change_amt_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (order_valid) begin
          if (y) begin
            recipe_d = {Sa, Sw, I, P};
            credit_d = '0;
            tmo_d    = '0;
            state_d  = S_PAY;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      S_PAY: begin
        if (coin_valid) begin
          credit_d = credit_add_c;
          tmo_d    = '0;
        end else begin
          tmo_d = tmo_inc_c;
        end
        // Cancel wins over a coin that would have reached the price
        if (cancel) begin
          state_d        = S_CHANGE;
          change_valid_d = (refund_c != '0);
          change_amt_d   = refund_c;
        end else if (coin_valid && (credit_add_c >= CREDIT_W'(PRICE))) begin
          state_d    = S_DISPENSE;
          dcnt_d     = DCNT_W'(DISPENSE_CYCLES);
          dispense_d = 1'b1;
        end else if (!coin_valid && (tmo_inc_c == TMO_W'(TIMEOUT))) begin
          state_d        = S_CHANGE;
          change_valid_d = (credit_q != '0);
          change_amt_d   = credit_q;
        end
      end

      S_DISPENSE: begin
        if (dcnt_q == DCNT_W'(1)) begin
          state_d        = S_CHANGE;
          change_valid_d = (credit_q != CREDIT_W'(PRICE));
          change_amt_d   = credit_q - CREDIT_W'(PRICE);
        end else begin
          dcnt_d     = dcnt_q - DCNT_W'(1);
          dispense_d = 1'b1;
        end
      end

      S_CHANGE: begin
        state_d  = S_IDLE;
        credit_d = '0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      recipe_q       <= '0;
      credit_q       <= '0;
      tmo_q          <= '0;
      dcnt_q         <= '0;
      dispense_q     <= 1'b0;
      reject_q       <= 1'b0;
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
    end else begin
      state_q        <= state_d;
      recipe_q       <= recipe_d;
      credit_q       <= credit_d;
      tmo_q          <= tmo_d;
      dcnt_q         <= dcnt_d;
      dispense_q     <= dispense_d;
      reject_q       <= reject_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
    end
  end

  assign order_ready  = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign recipe       = recipe_q;
  assign credit       = credit_q;
  assign dispense     = dispense_q;
  assign reject       = reject_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;

endmodule

// File: tb/tb_icecream_vend_ctrl.sv
// Directed bench for icecream_vend_ctrl; change pulses are checked against a queue
// of amounts pushed when the triggering stimulus is driven.
module tb_icecream_vend_ctrl;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          order_valid;
  logic          Sa, Sw, I, P;
  logic          y;
  logic          coin_valid;
  logic [1:0]    coin_val;
  logic          cancel;
  logic          order_ready;
  logic          busy;
  logic [3:0]    recipe;
  logic [CW-1:0] credit;
  logic          dispense;
  logic          reject;
  logic          change_valid;
  logic [CW-1:0] change_amt;

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];

  icecream_vend_ctrl #(
    .PRICE          (30),
    .DISPENSE_CYCLES(8),
    .TIMEOUT        (16),
    .CREDIT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .order_valid (order_valid),
    .Sa          (Sa),
    .Sw          (Sw),
    .I           (I),
    .P           (P),
    .y           (y),
    .coin_valid  (coin_valid),
    .coin_val    (coin_val),
    .cancel      (cancel),
    .order_ready (order_ready),
    .busy        (busy),
    .recipe      (recipe),
    .credit      (credit),
    .dispense    (dispense),
    .reject      (reject),
    .change_valid(change_valid),
    .change_amt  (change_amt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs set before the call are sampled, outputs read #1 later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic order(input logic [3:0] sel, input logic ok);
    order_valid = 1'b1;
    {Sa, Sw, I, P} = sel;
    y = ok;
    tick();
    order_valid = 1'b0;
    y = 1'b0;
  endtask

  task automatic coin(input logic [1:0] code);
    coin_valid = 1'b1;
    coin_val   = code;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic dispense_window();
    for (int i = 0; i < 8; i++) begin
      check("dispense_high", dispense, 1);
      if (i < 7) tick();
    end
    tick();
    check("dispense_low_after", dispense, 0);
  endtask

  // Scoreboard: every change pulse must match the oldest pending amount
  always @(negedge clk) begin
    if (rst_n === 1'b1 && change_valid === 1'b1) begin
      check("change_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("change_amt_sb", change_amt, exp_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; order_valid = 1'b0; {Sa, Sw, I, P} = 4'b0000; y = 1'b0;
    coin_valid = 1'b0; coin_val = 2'b00; cancel = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_ready", order_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_credit", credit, 0);
    check("rst_recipe", recipe, 0);
    check("rst_dispense", dispense, 0);
    check("rst_reject", reject, 0);
    check("rst_change_valid", change_valid, 0);

    // Exact payment
    order(4'b1100, 1'b1);
    check("exact_busy", busy, 1);
    check("exact_ready", order_ready, 0);
    check("exact_recipe", recipe, 4'b1100);
    coin(2'b01);
    check("exact_credit10", credit, 10);
    coin(2'b10);
    check("exact_credit30", credit, 30);
    dispense_window();
    check("exact_no_change", change_valid, 0);
    check("exact_change_amt0", change_amt, 0);
    check("exact_busy_change", busy, 1);
    tick();
    check("exact_idle", order_ready, 1);

    // Overpayment
    order(4'b0011, 1'b1);
    coin(2'b10);
    exp_q.push_back(10);
    coin(2'b10);
    check("over_credit40", credit, 40);
    dispense_window();
    check("over_change_valid", change_valid, 1);
    check("over_change_amt", change_amt, 10);
    tick();
    check("over_change_pulse", change_valid, 0);
    check("over_idle", order_ready, 1);
    check("over_credit_clr", credit, 0);

    // Rejected selection
    order(4'b0000, 1'b0);
    check("rej_pulse", reject, 1);
    check("rej_busy", busy, 0);
    check("rej_recipe", recipe, 4'b0011);
    tick();
    check("rej_pulse_end", reject, 0);
    coin(2'b11);
    check("rej_coin_ignored", credit, 0);
    check("rej_still_idle", busy, 0);

    // Cancel together with a coin
    order(4'b1010, 1'b1);
    coin(2'b01);
    check("cancel_credit10", credit, 10);
    coin_valid = 1'b1; coin_val = 2'b00; cancel = 1'b1;
    exp_q.push_back(15);
    tick();
    coin_valid = 1'b0; cancel = 1'b0;
    check("cancel_change_valid", change_valid, 1);
    check("cancel_change_amt", change_amt, 15);
    check("cancel_no_dispense", dispense, 0);
    tick();
    check("cancel_idle", order_ready, 1);

    // Cancel beats a coin that reaches the price
    order(4'b0101, 1'b1);
    coin(2'b10);
    coin_valid = 1'b1; coin_val = 2'b10; cancel = 1'b1;
    exp_q.push_back(40);
    tick();
    coin_valid = 1'b0; cancel = 1'b0;
    check("cancelprio_no_dispense", dispense, 0);
    check("cancelprio_amt", change_amt, 40);
    tick();
    check("cancelprio_idle", order_ready, 1);

    // Timeout refund
    order(4'b0110, 1'b1);
    coin(2'b00);
    exp_q.push_back(5);
    for (int i = 0; i < 15; i++) tick();
    check("tmo_still_pay", busy, 1);
    check("tmo_no_change_yet", change_valid, 0);
    tick();
    check("tmo_change_valid", change_valid, 1);
    check("tmo_change_amt", change_amt, 5);
    tick();
    check("tmo_idle", order_ready, 1);

    // Single 50 coin
    order(4'b1001, 1'b1);
    exp_q.push_back(20);
    coin(2'b11);
    check("c50_credit", credit, 50);
    dispense_window();
    check("c50_change_amt", change_amt, 20);
    tick();
    check("c50_idle", order_ready, 1);

    // Reset during dispense cycle 4
    order(4'b1111, 1'b1);
    coin(2'b11);
    tick(); tick(); tick();
    check("rstmid_disp4", dispense, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rstmid_dispense", dispense, 0);
    check("rstmid_credit", credit, 0);
    check("rstmid_ready", order_ready, 1);
    check("rstmid_recipe", recipe, 0);
    for (int i = 0; i < 3; i++) begin
      check("rstmid_no_change", change_valid, 0);
      tick();
    end
    order(4'b1100, 1'b1);
    coin(2'b01);
    coin(2'b10);
    dispense_window();
    tick();
    check("rstmid_fresh_idle", order_ready, 1);

    tick();
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icecream_vend_ctrl.md
# icecream_vend_ctrl

Sequential vend controller downstream of the combinational ice-cream recipe checker. It accepts a customer selection (Sa, Sw, I, P) together with the checker's approval bit y. It then collects coins, drives the dispenser for a fixed time, and returns change or a refund. It is the first clocked stage after the recipe decode and owns all payment and dispense timing.

## Interface
- PRICE, 30: cost of one serving, in credit units
- DISPENSE_CYCLES, 8: cycles dispense stays high; must be ≥ 1
- TIMEOUT, 255: idle cycles in PAY before auto-refund; must be ≥ 1
- CREDIT_W, 8: width of credit/change; must hold PRICE + 50

- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- order_valid  in  1  selection present this cycle; sampled only in IDLE
- Sa, Sw, I, P  in  1 each  selection bits, valid with order_valid
- y  in  1  recipe-checker approval for the presented selection
- coin_valid  in  1  one coin inserted this cycle
- coin_val  in  2  coin value: 00=5, 01=10, 10=20, 11=50
- cancel  in  1  customer abort request
- order_ready  out  1  high iff state is IDLE (combinational from state)
- busy  out  1  high iff state is not IDLE
- recipe  out  4  latched {Sa,Sw,I,P} of the accepted order
- credit  out  CREDIT_W  current accumulated credit
- dispense  out  1  dispenser drive
- reject  out  1  one-cycle pulse: selection not approved
- change_valid  out  1  one-cycle pulse: change_amt valid
- change_amt  out  CREDIT_W  amount returned

## Operation
- States: IDLE, PAY, DISPENSE, CHANGE.
- Reset (rst_n=0 at an edge): state becomes IDLE; recipe, credit, dispense, reject, change_valid, change_amt, timeout counter and dispense counter all become 0. Reset overrides everything, including mid-DISPENSE.
- IDLE, order_valid=1 and y=1: latch recipe, clear credit and timeout counter, go to PAY.
- IDLE, order_valid=1 and y=0: reject=1 for the next cycle; remain in IDLE; recipe unchanged.
- PAY, coin_valid=1:
  - credit += coin value, saturating at 2^CREDIT_W−1; timeout counter clears.
  - If the new credit ≥ PRICE, go to DISPENSE and load the dispense counter.
- PAY, cancel=1: go to CHANGE with refund = credit. A coin in the same cycle is added first, so refund includes it, even if that coin would reach PRICE. Cancel has priority over dispensing.
- PAY, no coin: timeout counter increments. When it reaches TIMEOUT, go to CHANGE with refund = credit.
- DISPENSE: dispense=1 for exactly DISPENSE_CYCLES cycles, then go to CHANGE with amount = credit − PRICE. cancel is ignored in this state.
- CHANGE: lasts one cycle, then go to IDLE and clear credit.
  - If amount > 0: change_valid=1 and change_amt=amount.
  - If amount = 0: change_valid stays 0 and change_amt=0.
- Coins in IDLE, DISPENSE or CHANGE are ignored; credit is unchanged.
- order_valid outside IDLE is ignored; no reject pulse.
- All outputs except order_ready and busy are registered.

## Timing
- Accepted order at edge N: PAY from N+1; order_ready low from N+1.
- Rejected order at edge N: reject high during cycle N+1 only.
- Coin reaching PRICE at edge N: dispense high cycles N+1 … N+DISPENSE_CYCLES.
- After that dispense window: CHANGE (change_valid high if amount > 0) in cycle N+DISPENSE_CYCLES+1; IDLE and order_ready=1 in cycle N+DISPENSE_CYCLES+2.
- Cancel or timeout at edge N: CHANGE in cycle N+1; IDLE in cycle N+2.
- credit reflects a coin one cycle after its edge.
- Minimum order-to-order spacing is 3 + DISPENSE_CYCLES cycles.

## Test plan
Bench parameters: PRICE=30, DISPENSE_CYCLES=8, TIMEOUT=16, CREDIT_W=8.
- Exact payment: order {1,1,0,0} with y=1, then coins 10, 20 → recipe=4'b1100; dispense high exactly 8 cycles; no change_valid; order_ready=1 two cycles after dispense falls.
- Overpayment: order with y=1, then coins 20, 20 → credit=40; 8-cycle dispense; single change_valid pulse with change_amt=10.
- Rejected selection: order {0,0,0,0} with y=0 → one reject pulse; busy stays 0; subsequent coin 50 ignored, credit=0.
- Cancel with coin: order y=1, coin 10, then cancel in the same cycle as coin 5 → no dispense; change_valid with change_amt=15; IDLE two cycles after cancel.
- Timeout: order y=1, coin 5, then 16 quiet cycles → change_amt=5 pulse, then IDLE. A separate run with coin 50 → dispense, then change_amt=20.
- Reset mid-operation: rst_n low for 1 cycle during dispense cycle 4 → next cycle dispense=0, credit=0, order_ready=1, no change pulse; then a fresh order completes normally.
